// File: rtl/alu_shift_seq.sv
// -----------------------------------------------------------------------------
// alu_shift_seq
//
// Multi-cycle sequencer for variable-count shift/rotate instructions. One
// single-bit shift/rotate step is pushed through the external combinational
// ALU per clock. Each step's result is fed back as the next operand, and the
// ALU flags selected by the opcode are merged into a running flag register.
//
// Optional feature macro: ALU_SHIFT_SEQ_ABORT_EN
//   When defined, adds the 'abort' input. Abort in RUN or FIN returns the
//   sequencer to IDLE and suppresses done. Abort in IDLE is ignored, and it
//   blocks a start presented in the same cycle.
//
// Ports:
//   clk        in   1   system clock
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   request strobe, sampled only in IDLE
//   op         in   5   ALUOP code (ROL=8, ROR=9, SHL=12, SHR=13, SHRA=15)
//   size       in   1   0 = byte, 1 = word
//   operand    in  16   value to shift
//   count      in   8   raw shift count; only the low CNT_BITS bits are used
//   flags_in   in   6   PSW flags {Z,S,P,V,CY,AC} (AC at bit 0)
//   abort      in   1   (ALU_SHIFT_SEQ_ABORT_EN only) cancel the sequence
//   busy       out  1   high in RUN and FIN
//   done       out  1   one-cycle completion pulse
//   result     out 16   final value, valid with done
//   flags_out  out  6   merged flags, valid with done
//   alu_op     out  5   opcode presented to the ALU
//   alu_size   out  1   size presented to the ALU
//   alu_a      out 16   working operand presented to the ALU
//   alu_b      out 16   16'd1 while RUN, otherwise 16'd0
//   alu_r      in  16   ALU result
//   alu_flags  in   6   ALU flag output
// -----------------------------------------------------------------------------
module alu_shift_seq #(
  parameter int CNT_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [4:0]          op,
  input  logic                size,
  input  logic [15:0]         operand,
  input  logic [7:0]          count,
  input  logic [5:0]          flags_in,
`ifdef ALU_SHIFT_SEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic                busy,
  output logic                done,
  output logic [15:0]         result,
  output logic [5:0]          flags_out,
  output logic [4:0]          alu_op,
  output logic                alu_size,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  input  logic [15:0]         alu_r,
  input  logic [5:0]          alu_flags
);

  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd12;
  localparam logic [4:0] OP_SHR  = 5'd13;
  localparam logic [4:0] OP_SHRA = 5'd15;

  localparam logic [CNT_BITS-1:0] N_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] N_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Opcodes this block knows how to sequence; anything else is a pass-through.
  function automatic logic op_legal(input logic [4:0] o);
    logic ok;
    case (o)
      OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SHRA: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Flags an ALU step is allowed to update. Rotates only touch CY and V;
  // shifts also update P, S, Z. AC (bit 0) is never written.
  function automatic logic [5:0] flag_mask(input logic [4:0] o);
    logic [5:0] m;
    case (o)
      OP_ROL, OP_ROR:           m = 6'b000110;
      OP_SHL, OP_SHR, OP_SHRA:  m = 6'b111110;
      default:                  m = 6'b000000;
    endcase
    return m;
  endfunction

  state_t              state_q,     state_d;
  logic [4:0]          op_q,        op_d;
  logic                size_q,      size_d;
  logic [15:0]         work_q,      work_d;
  logic [7:0]          hi_q,        hi_d;
  logic [5:0]          flag_q,      flag_d;
  logic [CNT_BITS-1:0] n_q,         n_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic [15:0]         result_q,    result_d;
  logic [5:0]          flags_out_q, flags_out_d;
  logic [15:0]         alu_b_q,     alu_b_d;

  logic                abort_s;
  logic [CNT_BITS-1:0] cnt_s;
  logic [5:0]          merged_s;
  logic                unused_count_s;

`ifdef ALU_SHIFT_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Count bits above CNT_BITS are deliberately ignored.
  assign cnt_s          = count[CNT_BITS-1:0];
  assign unused_count_s = ^count;

  // Flag register after applying the current ALU step.
  assign merged_s = (flag_q & ~flag_mask(op_q)) | (alu_flags & flag_mask(op_q));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    work_d      = work_q;
    hi_d        = hi_q;
    flag_d      = flag_q;
    n_d         = n_q;
    result_d    = result_q;
    flags_out_d = flags_out_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort_s) begin
          op_d   = op;
          size_d = size;
          work_d = operand;
          hi_d   = operand[15:8];
          flag_d = flags_in;
          if (op_legal(op) && (cnt_s != N_ZERO)) begin
            n_d     = cnt_s;
            state_d = S_RUN;
          end else begin
            // Zero count or unknown opcode: report the operand untouched.
            n_d         = N_ZERO;
            state_d     = S_FIN;
            result_d    = operand;
            flags_out_d = flags_in;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (abort_s) begin
          state_d = S_IDLE;
        end else begin
          work_d = alu_r;
          flag_d = merged_s;
          n_d    = n_q - N_ONE;
          if (n_q == N_ONE) begin
            // Last step: capture the final value so it is valid during FIN.
            // Byte ops always report the original upper byte.
            state_d     = S_FIN;
            result_d    = size_q ? alu_r : {hi_q, alu_r[7:0]};
            flags_out_d = merged_s;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered, so derive them from the next state.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    alu_b_d = (state_d == S_RUN) ? 16'd1 : 16'd0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      size_q      <= 1'b0;
      work_q      <= 16'd0;
      hi_q        <= 8'd0;
      flag_q      <= 6'd0;
      n_q         <= N_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 16'd0;
      flags_out_q <= 6'd0;
      alu_b_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      size_q      <= size_d;
      work_q      <= work_d;
      hi_q        <= hi_d;
      flag_q      <= flag_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      flags_out_q <= flags_out_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign busy      = busy_q;
  assign result    = result_q;
  assign flags_out = flags_out_q;
  assign alu_op    = op_q;
  assign alu_size  = size_q;
  assign alu_a     = work_q;
  assign alu_b     = alu_b_q;

`ifdef ALU_SHIFT_SEQ_ABORT_EN
  // An abort arriving during FIN must still cancel the completion pulse.
  assign done = done_q & ~abort_s;
`else
  assign done = done_q;
`endif

endmodule
